// File: rtl/shift_sequencer.sv
// Multi-cycle operand-2 shifter sequencer for the execute stage.
// Computes the ARM shifter operand and carry-out at STEP bits per clock. While it works it stalls the pipeline.
module shift_sequencer #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] rm_in,
  input  logic [11:0] shift_in,
  input  logic [2:0]  type_in,
  input  logic        carry_in,
  output logic [31:0] shifter_out,
  output logic        shifter_carry_out,
  output logic        done,
  output logic        busy,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_e;

  localparam logic [5:0] STEP_W = 6'(STEP);

  // Handshake: start is a single-cycle request, accepted only in IDLE or DONE.
  // done pulses for exactly one cycle. The result stays on shifter_out until the next done.
  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] rm_q, rm_d;
  logic [11:0] sh_q, sh_d;
  logic [2:0]  ty_q, ty_d;
  logic        cin_q, cin_d;
  logic [31:0] w_q, w_d;
  logic        c_q, c_d;
  logic [5:0]  n_q, n_d;
  logic [31:0] out_q, out_d;
  logic        cout_q, cout_d;

  logic [4:0]  amt;
  logic [5:0]  k;
  logic [31:0] wt;
  logic        ct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LSL;
      rm_q    <= '0;
      sh_q    <= '0;
      ty_q    <= '0;
      cin_q   <= 1'b0;
      w_q     <= '0;
      c_q     <= 1'b0;
      n_q     <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rm_q    <= rm_d;
      sh_q    <= sh_d;
      ty_q    <= ty_d;
      cin_q   <= cin_d;
      w_q     <= w_d;
      c_q     <= c_d;
      n_q     <= n_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rm_d    = rm_q;
    sh_d    = sh_q;
    ty_d    = ty_q;
    cin_d   = cin_q;
    w_d     = w_q;
    c_d     = c_q;
    n_d     = n_q;
    out_d   = out_q;
    cout_d  = cout_q;
    amt     = sh_q[11:7];
    k       = (n_q < STEP_W) ? n_q : STEP_W;
    wt      = w_q;
    ct      = c_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          rm_d    = rm_in;
          sh_d    = shift_in;
          ty_d    = type_in;
          cin_d   = carry_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        c_d  = cin_q;
        w_d  = rm_q;
        op_d = OP_LSL;
        n_d  = '0;
        case (ty_q)
          3'b001: begin
            w_d  = {24'b0, sh_q[7:0]};
            op_d = OP_ROR;
            n_d  = {1'b0, sh_q[11:8], 1'b0};
          end
          3'b000: begin
            // An immediate amount of 0 encodes #32 for LSR/ASR and RRX for ROR.
            case (sh_q[6:5])
              2'b00: begin op_d = OP_LSL; n_d = {1'b0, amt}; end
              2'b01: begin op_d = OP_LSR; n_d = (amt == 5'd0) ? 6'd32 : {1'b0, amt}; end
              2'b10: begin op_d = OP_ASR; n_d = (amt == 5'd0) ? 6'd32 : {1'b0, amt}; end
              default: begin
                op_d = (amt == 5'd0) ? OP_RRX : OP_ROR;
                n_d  = (amt == 5'd0) ? 6'd1 : {1'b0, amt};
              end
            endcase
          end
          3'b010: w_d = {20'b0, sh_q};
          default: w_d = rm_q;
        endcase
        state_d = (n_d != 6'd0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        for (int i = 0; i < STEP; i++) begin
          if (6'(i) < k) begin
            case (op_q)
              OP_LSL:  begin ct = wt[31]; wt = {wt[30:0], 1'b0}; end
              OP_LSR:  begin ct = wt[0];  wt = {1'b0, wt[31:1]}; end
              OP_ASR:  begin ct = wt[0];  wt = {wt[31], wt[31:1]}; end
              OP_ROR:  begin ct = wt[0];  wt = {wt[0], wt[31:1]}; end
              OP_RRX:  begin wt = {ct, wt[31:1]}; ct = w_q[0]; end
              default: begin ct = ct; wt = wt; end
            endcase
          end
        end
        w_d = wt;
        c_d = ct;
        n_d = n_q - k;
        if (n_d == 6'd0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // The outputs are loaded only on the transition into DONE.
    if (state_d == S_DONE) begin
      out_d  = w_d;
      cout_d = c_d;
    end
  end

  assign shifter_out       = out_q;
  assign shifter_carry_out = cout_q;
  assign done              = (state_q == S_DONE);
  assign busy              = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign stall             = busy | (start & (state_q == S_IDLE));
  assign dbg_state         = state_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle sequencer for the operand-2 shifter in the execute stage.
- Accepts a one-cycle start pulse with Rm, the 12-bit shifter field and the instruction-type code, then shifts STEP bit positions per clock.
- Produces the ARM-correct shifter operand and shifter carry-out, with a one-cycle done pulse.
- Drives a stall to the pipeline while an operation is in flight.

Parameters:
- STEP, 1, bit positions shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; operands are sampled on the same edge.
- rm_in  in  32  Rm register value.
- shift_in  in  12  instruction bits [11:0].
- type_in  in  3  instruction type: 000 DP immediate shift, 001 DP immediate rotate, 010 LS immediate offset, 011 LS register offset.
- carry_in  in  1  current CPSR C flag.
- shifter_out  out  32  result; held stable until the next done.
- shifter_carry_out  out  1  shifter carry; held with the result.
- done  out  1  one-cycle pulse; result valid in this cycle.
- busy  out  1  high in states LOAD and SHIFT.
- stall  out  1  combinational: busy | (start & state==IDLE).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; shifter_out=0, shifter_carry_out=0, done=0, busy=0; internal count and operand registers cleared.
  - Reset mid-operation aborts it; no done is produced.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE/DONE -> LOAD when start=1: capture rm_in, shift_in, type_in, carry_in.
  - start is accepted in DONE, so back-to-back operations are allowed.
  - start in LOAD or SHIFT is ignored and does not affect the current operation.
- LOAD (1 cycle): initialise working value W, carry register C=carry_in, opcode and count N as follows.
  - 001: W=zero-extended shift_in[7:0]; op=ROR; N=2*shift_in[11:8] (0..30).
  - 000, amount a=shift_in[11:7], op=shift_in[6:5]:
    - LSL: N=a.
    - LSR/ASR: N = (a==0) ? 32 : a.
    - ROR with a!=0: N=a.
    - ROR with a==0: RRX, N=1.
    - W=rm_in in all cases.
  - 010: W=zero-extended shift_in, N=0.
  - 011: W=rm_in, N=0.
  - 100-111: W=rm_in, N=0.
  - Next state: SHIFT if N>0, else DONE.
- SHIFT, one edge per iteration; k=min(STEP,N); N decrements by k; go to DONE when N reaches 0.
  - LSL: C = bit shifted out of W[31]; zero fill.
  - LSR: C = bit shifted out of W[0]; zero fill.
  - ASR: C = bit shifted out of W[0]; fill with W[31].
  - ROR: C = last bit rotated; bits from W[0] enter W[31].
  - RRX: 33-bit rotate {C,W} right by 1, i.e. W={C,W[31:1]}, C=old W[0].
- DONE (1 cycle): done=1; shifter_out=W, shifter_carry_out=C registered at DONE entry.
  - N=0 cases keep C=carry_in (LSL #0, rotate-immediate #0, load/store types).
  - Next state is LOAD if start=1, else IDLE.
- Latency, counted from the start edge to the edge at which done first reads high: 2 + ceil(N/STEP) cycles.
- Outputs never change except on DONE entry or reset.

Test Plan:
- rm_in=0x80000001, type 000, LSL #1, carry_in=0, STEP=1 -> done 3 edges after start; shifter_out=0x00000002, carry=1.
- rm_in=0x80000000, type 000, ASR a=0 (#32), STEP=1 -> 34-edge latency; shifter_out=0xFFFFFFFF, carry=1; busy/stall high throughout.
- rm_in=0x00000003, ROR a=0 (RRX), carry_in=1 -> shifter_out=0x80000001, carry=1. Same with LSR a=0 -> shifter_out=0, carry=0.
- type 001, shift_in=0x4FF (rot 4 -> ROR 8), STEP=4 -> shifter_out=0xFF000000, carry=1, latency 4.
- type 010, shift_in=0xABC, carry_in=1 -> shifter_out=0x00000ABC, carry=1, latency 2.
- Back-to-back start in DONE: second op latency unchanged. start pulsed during SHIFT: ignored. rst_n low mid-SHIFT: outputs 0, no done, IDLE.
